// File: rtl/set_associative_cache_array_if.sv
// ----------------------------------------------------------------------------
// set_associative_cache_array_if
//
// Purpose: groups the CPU-side, snoop-side and line-fill signals of the
// set-associative cache array into one bundle.
//
//   master modport : the controllers / bus side (drives addresses, write
//                    strobes and fill beats, observes lookup results)
//   slave modport  : the cache array itself
//
// Signal summary
//   CPU   : cpuIndex/cpuTag/cpuOffset, cpuWriteData/cpuDataIn,
//           cpuWriteState/cpuStateIn, accessEnable  ->  cpuHit, cpuWay,
//           cpuTagOut, cpuDataOut, cpuStateOut
//   Snoop : snoopIndex/snoopTag/snoopOffset, snoopWriteState/snoopStateIn
//           ->  snoopHit, snoopWay, snoopDataOut, snoopStateOut
//   Fill  : fillStart, fillIndex, fillTag, fillState, fillValid, fillData
//           ->  fillBusy, fillDone, fillVictimTag, fillVictimState
// ----------------------------------------------------------------------------
interface set_associative_cache_array_if #(
    parameter int TAG_WIDTH         = 6,
    parameter int INDEX_WIDTH       = 4,
    parameter int OFFSET_WIDTH      = 4,
    parameter int SET_ASSOCIATIVITY = 2,
    parameter int DATA_WIDTH        = 16,
    parameter int STATE_WIDTH       = 2
);
    // CPU port
    logic [INDEX_WIDTH-1:0]       cpuIndex;
    logic [TAG_WIDTH-1:0]         cpuTag;
    logic [OFFSET_WIDTH-1:0]      cpuOffset;
    logic                         cpuHit;
    logic [SET_ASSOCIATIVITY-1:0] cpuWay;
    logic [TAG_WIDTH-1:0]         cpuTagOut;
    logic [DATA_WIDTH-1:0]        cpuDataOut;
    logic [STATE_WIDTH-1:0]       cpuStateOut;
    logic                         cpuWriteData;
    logic [DATA_WIDTH-1:0]        cpuDataIn;
    logic                         cpuWriteState;
    logic [STATE_WIDTH-1:0]       cpuStateIn;
    logic                         accessEnable;

    // Snoop port
    logic [INDEX_WIDTH-1:0]       snoopIndex;
    logic [TAG_WIDTH-1:0]         snoopTag;
    logic [OFFSET_WIDTH-1:0]      snoopOffset;
    logic                         snoopHit;
    logic [SET_ASSOCIATIVITY-1:0] snoopWay;
    logic [DATA_WIDTH-1:0]        snoopDataOut;
    logic [STATE_WIDTH-1:0]       snoopStateOut;
    logic                         snoopWriteState;
    logic [STATE_WIDTH-1:0]       snoopStateIn;

    // Line-fill engine
    logic                         fillStart;
    logic [INDEX_WIDTH-1:0]       fillIndex;
    logic [TAG_WIDTH-1:0]         fillTag;
    logic [STATE_WIDTH-1:0]       fillState;
    logic                         fillValid;
    logic [DATA_WIDTH-1:0]        fillData;
    logic                         fillBusy;
    logic                         fillDone;
    logic [TAG_WIDTH-1:0]         fillVictimTag;
    logic [STATE_WIDTH-1:0]       fillVictimState;

    modport master (
        output cpuIndex, cpuTag, cpuOffset, cpuWriteData, cpuDataIn,
               cpuWriteState, cpuStateIn, accessEnable,
               snoopIndex, snoopTag, snoopOffset, snoopWriteState, snoopStateIn,
               fillStart, fillIndex, fillTag, fillState, fillValid, fillData,
        input  cpuHit, cpuWay, cpuTagOut, cpuDataOut, cpuStateOut,
               snoopHit, snoopWay, snoopDataOut, snoopStateOut,
               fillBusy, fillDone, fillVictimTag, fillVictimState
    );

    modport slave (
        input  cpuIndex, cpuTag, cpuOffset, cpuWriteData, cpuDataIn,
               cpuWriteState, cpuStateIn, accessEnable,
               snoopIndex, snoopTag, snoopOffset, snoopWriteState, snoopStateIn,
               fillStart, fillIndex, fillTag, fillState, fillValid, fillData,
        output cpuHit, cpuWay, cpuTagOut, cpuDataOut, cpuStateOut,
               snoopHit, snoopWay, snoopDataOut, snoopStateOut,
               fillBusy, fillDone, fillVictimTag, fillVictimState
    );
endinterface

// File: rtl/set_associative_cache_array.sv
// ----------------------------------------------------------------------------
// set_associative_cache_array
//
// Purpose: N-way set-associative tag/state/data array with per-set LRU ages
// and a burst line-fill engine. The CPU and snoop ports look up
// combinationally from the stored arrays; every write lands on the next
// rising clock edge.
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : set_associative_cache_array_if.slave (CPU, snoop and fill groups)
//   hitCount / missCount (only with CACHE_ARRAY_STATS_EN defined): 32-bit
//            saturating counts of accessEnable cycles that hit / missed.
//
// Optional feature macro: CACHE_ARRAY_STATS_EN
// ----------------------------------------------------------------------------
module set_associative_cache_array #(
    parameter int TAG_WIDTH         = 6,
    parameter int INDEX_WIDTH       = 4,
    parameter int OFFSET_WIDTH      = 4,
    parameter int SET_ASSOCIATIVITY = 2,
    parameter int DATA_WIDTH        = 16,
    parameter int STATE_WIDTH       = 2,
    parameter int INVALID_STATE     = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    set_associative_cache_array_if.slave  bus
`ifdef CACHE_ARRAY_STATS_EN
    ,
    output logic [31:0]                   hitCount,
    output logic [31:0]                   missCount
`endif
);
    localparam int WAYS  = 1 << SET_ASSOCIATIVITY;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << OFFSET_WIDTH;
    localparam logic [STATE_WIDTH-1:0] INV = STATE_WIDTH'(INVALID_STATE);

    typedef logic [SET_ASSOCIATIVITY-1:0]           way_t;
    typedef logic [WAYS-1:0][SET_ASSOCIATIVITY-1:0] ages_t;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} fsm_t;

    // Storage
    logic [TAG_WIDTH-1:0]   tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]  data_q  [SETS][WAYS][WORDS];
    logic [STATE_WIDTH-1:0] state_q [SETS][WAYS];
    logic [STATE_WIDTH-1:0] state_d [SETS][WAYS];
    ages_t                  age_q   [SETS];
    ages_t                  age_d   [SETS];

    // Fill engine registers
    fsm_t                    fsm_q;
    logic                    fillBusy_q, fillDone_q;
    logic [INDEX_WIDTH-1:0]  fidx_q;
    logic [TAG_WIDTH-1:0]    ftag_q;
    logic [STATE_WIDTH-1:0]  fstate_q;
    way_t                    fway_q;
    logic [OFFSET_WIDTH-1:0] beat_q;
    logic [TAG_WIDTH-1:0]    vtag_q;
    logic [STATE_WIDTH-1:0]  vstate_q;

    // Lowest-index invalid way, otherwise the oldest way (age WAYS-1).
    function automatic way_t pick_victim(input logic [WAYS-1:0] valid, input ages_t ages);
        way_t v;
        logic found;
        v     = '0;
        found = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                v     = way_t'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < WAYS; i++) begin
                if (ages[i] == way_t'(WAYS - 1)) v = way_t'(i);
            end
        end
        return v;
    endfunction

    function automatic way_t first_set(input logic [WAYS-1:0] v);
        way_t r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) r = way_t'(i);
        end
        return r;
    endfunction

    // Make way w youngest; everything younger than it ages by one.
    function automatic ages_t lru_touch(input ages_t ages, input way_t w);
        ages_t r;
        r = ages;
        for (int i = 0; i < WAYS; i++) begin
            if (way_t'(i) == w)        r[i] = '0;
            else if (ages[i] < ages[w]) r[i] = ages[i] + way_t'(1);
        end
        return r;
    endfunction

    // Make way w oldest; everything older than it gets one step younger.
    function automatic ages_t lru_demote(input ages_t ages, input way_t w);
        ages_t r;
        r = ages;
        for (int i = 0; i < WAYS; i++) begin
            if (way_t'(i) == w)        r[i] = way_t'(WAYS - 1);
            else if (ages[i] > ages[w]) r[i] = ages[i] - way_t'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational lookups
    // ------------------------------------------------------------------
    logic [WAYS-1:0] cpu_valid, cpu_match, snp_match, fill_valid;
    logic            cpu_hit, snp_hit;
    way_t            cpu_way, snp_way, fill_victim;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            cpu_valid[w]  = state_q[bus.cpuIndex][w] != INV;
            cpu_match[w]  = cpu_valid[w] && (tag_q[bus.cpuIndex][w] == bus.cpuTag);
            snp_match[w]  = (state_q[bus.snoopIndex][w] != INV) &&
                            (tag_q[bus.snoopIndex][w] == bus.snoopTag);
            fill_valid[w] = state_q[bus.fillIndex][w] != INV;
        end
    end

    assign cpu_hit     = |cpu_match;
    assign cpu_way     = cpu_hit ? first_set(cpu_match)
                                 : pick_victim(cpu_valid, age_q[bus.cpuIndex]);
    assign snp_hit     = |snp_match;
    assign snp_way     = snp_hit ? first_set(snp_match) : '0;
    assign fill_victim = pick_victim(fill_valid, age_q[bus.fillIndex]);

    assign bus.cpuHit        = cpu_hit;
    assign bus.cpuWay        = cpu_way;
    assign bus.cpuTagOut     = tag_q[bus.cpuIndex][cpu_way];
    assign bus.cpuDataOut    = data_q[bus.cpuIndex][cpu_way][bus.cpuOffset];
    assign bus.cpuStateOut   = state_q[bus.cpuIndex][cpu_way];
    assign bus.snoopHit      = snp_hit;
    assign bus.snoopWay      = snp_way;
    assign bus.snoopDataOut  = snp_hit ? data_q[bus.snoopIndex][snp_way][bus.snoopOffset] : '0;
    assign bus.snoopStateOut = snp_hit ? state_q[bus.snoopIndex][snp_way] : INV;

    assign bus.fillBusy        = fillBusy_q;
    assign bus.fillDone        = fillDone_q;
    assign bus.fillVictimTag   = vtag_q;
    assign bus.fillVictimState = vstate_q;

    logic fill_beat, commit, snp_wr, snp_inv;
    assign fill_beat = (fsm_q == FILL) && bus.fillValid;
    assign commit    = (fsm_q == COMMIT);
    assign snp_wr    = bus.snoopWriteState && snp_hit;
    assign snp_inv   = snp_wr && (bus.snoopStateIn == INV);

    // ------------------------------------------------------------------
    // Next-state for coherence state and LRU ages. Later assignments win:
    // CPU, then snoop, then fill commit.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.cpuWriteState) state_d[bus.cpuIndex][cpu_way] = bus.cpuStateIn;
        if (snp_wr)            state_d[bus.snoopIndex][snp_way] = bus.snoopStateIn;
        if (commit)            state_d[fidx_q][fway_q] = fstate_q;
    end

    always_comb begin
        age_d = age_q;
        if (bus.accessEnable) age_d[bus.cpuIndex] = lru_touch(age_d[bus.cpuIndex], cpu_way);
        if (snp_inv)          age_d[bus.snoopIndex] = lru_demote(age_d[bus.snoopIndex], snp_way);
        if (commit)           age_d[fidx_q] = lru_touch(age_d[fidx_q], fway_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    state_q[s][w] <= INV;
                    age_q[s][w]   <= way_t'(WAYS - 1 - w);
                end
            end
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end

    // Tag and data arrays carry no reset; validity lives in state_q.
    // A fill beat is written after the CPU word so it overrides a CPU write
    // to the same word.
    always_ff @(posedge clock) begin
        if (bus.cpuWriteData) data_q[bus.cpuIndex][cpu_way][bus.cpuOffset] <= bus.cpuDataIn;
        if (fill_beat)        data_q[fidx_q][fway_q][beat_q] <= bus.fillData;
        if (commit)           tag_q[fidx_q][fway_q] <= ftag_q;
    end

    // ------------------------------------------------------------------
    // Line-fill FSM: IDLE -> FILL (2**OFFSET_WIDTH beats) -> COMMIT -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q      <= IDLE;
            fillBusy_q <= 1'b0;
            fillDone_q <= 1'b0;
            fidx_q     <= '0;
            ftag_q     <= '0;
            fstate_q   <= INV;
            fway_q     <= '0;
            beat_q     <= '0;
            vtag_q     <= '0;
            vstate_q   <= INV;
        end else begin
            fillDone_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.fillStart) begin
                        fsm_q      <= FILL;
                        fillBusy_q <= 1'b1;
                        fidx_q     <= bus.fillIndex;
                        ftag_q     <= bus.fillTag;
                        fstate_q   <= bus.fillState;
                        fway_q     <= fill_victim;
                        beat_q     <= '0;
                        vtag_q     <= tag_q[bus.fillIndex][fill_victim];
                        vstate_q   <= state_q[bus.fillIndex][fill_victim];
                    end
                end
                FILL: begin
                    if (bus.fillValid) begin
                        beat_q <= beat_q + OFFSET_WIDTH'(1);
                        // fillDone is raised on entry so it is high exactly
                        // during the COMMIT cycle.
                        if (&beat_q) begin
                            fsm_q      <= COMMIT;
                            fillDone_q <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    fsm_q      <= IDLE;
                    fillBusy_q <= 1'b0;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_ARRAY_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (bus.accessEnable) begin
            if (cpu_hit) begin
                if (hit_q != '1) hit_q <= hit_q + 32'd1;
            end else begin
                if (miss_q != '1) miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hitCount  = hit_q;
    assign missCount = miss_q;
`endif
endmodule

// File: tb/tb_set_associative_cache_array.sv
module tb_set_associative_cache_array;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    set_associative_cache_array_if bus ();

`ifdef CACHE_ARRAY_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    set_associative_cache_array dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef CACHE_ARRAY_STATS_EN
        ,
        .hitCount  (hitCount),
        .missCount (missCount)
`endif
    );

    // Output selectors for the scoreboard
    localparam int S_CHIT = 0, S_CWAY = 1, S_CSTATE = 2, S_CDATA = 3, S_CTAG = 4;
    localparam int S_SHIT = 5, S_SWAY = 6, S_SSTATE = 7, S_SDATA = 8;
    localparam int S_BUSY = 9, S_VTAG = 10, S_VSTATE = 11;

    typedef struct {
        string       name;
        int          sel;
        int unsigned val;
    } exp_t;

    exp_t chk_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int unsigned dut_out(input int sel);
        case (sel)
            S_CHIT:   return 32'(bus.cpuHit);
            S_CWAY:   return 32'(bus.cpuWay);
            S_CSTATE: return 32'(bus.cpuStateOut);
            S_CDATA:  return 32'(bus.cpuDataOut);
            S_CTAG:   return 32'(bus.cpuTagOut);
            S_SHIT:   return 32'(bus.snoopHit);
            S_SWAY:   return 32'(bus.snoopWay);
            S_SSTATE: return 32'(bus.snoopStateOut);
            S_SDATA:  return 32'(bus.snoopDataOut);
            S_BUSY:   return 32'(bus.fillBusy);
            S_VTAG:   return 32'(bus.fillVictimTag);
            S_VSTATE: return 32'(bus.fillVictimState);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string name, input int sel, input int unsigned val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        chk_q.push_back(e);
    endtask

    // Monitor: drains pending expectations on every falling edge, and pairs
    // every fillDone pulse with an expected completion.
    always @(negedge clock) begin
        while (chk_q.size() > 0) begin
            exp_t e;
            int unsigned got;
            e   = chk_q.pop_front();
            got = dut_out(e.sel);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, got, e.val, $time);
            end
        end
        if (bus.fillDone === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL fillDone_unexpected: got 1, expected 0 at %0t", $time);
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpuIndex = '0;  bus.cpuTag = '0;  bus.cpuOffset = '0;
        bus.cpuWriteData = 1'b0;  bus.cpuDataIn = '0;
        bus.cpuWriteState = 1'b0; bus.cpuStateIn = '0;
        bus.accessEnable = 1'b0;
        bus.snoopIndex = '0; bus.snoopTag = '0; bus.snoopOffset = '0;
        bus.snoopWriteState = 1'b0; bus.snoopStateIn = '0;
        bus.fillStart = 1'b0; bus.fillIndex = '0; bus.fillTag = '0; bus.fillState = '0;
        bus.fillValid = 1'b0; bus.fillData = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic cpu_look(input logic [3:0] idx, input logic [5:0] tag, input logic [3:0] off);
        bus.cpuIndex = idx; bus.cpuTag = tag; bus.cpuOffset = off;
    endtask

    task automatic snoop_look(input logic [3:0] idx, input logic [5:0] tag, input logic [3:0] off);
        bus.snoopIndex = idx; bus.snoopTag = tag; bus.snoopOffset = off;
    endtask

    task automatic fill_start(input logic [3:0] idx, input logic [5:0] tag, input logic [1:0] st);
        bus.fillStart = 1'b1; bus.fillIndex = idx; bus.fillTag = tag; bus.fillState = st;
        tick();
        bus.fillStart = 1'b0;
        expect_out("fill_busy_after_start", S_BUSY, 1);
    endtask

    task automatic fill_beats(input logic [15:0] base, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            bus.fillValid = 1'b1;
            bus.fillData  = base + 16'(k);
            tick();
            bus.fillValid = 1'b0;
            if (gaps && (k % 3 == 1)) tick();
        end
    endtask

    // Full fill: start, 16 beats, then let the COMMIT cycle pass.
    task automatic fill_line(input logic [3:0] idx, input logic [5:0] tag, input logic [1:0] st,
                             input logic [15:0] base, input bit gaps);
        done_q.push_back(1);
        fill_start(idx, tag, st);
        fill_beats(base, 16, gaps);
        tick();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        cpu_look(4'd3, 6'd5, 4'd0);
        snoop_look(4'd3, 6'd5, 4'd0);
        expect_out("rst_cpuHit", S_CHIT, 0);
        expect_out("rst_cpuWay", S_CWAY, 0);
        expect_out("rst_cpuState", S_CSTATE, 0);
        expect_out("rst_snoopHit", S_SHIT, 0);
        expect_out("rst_snoopWay", S_SWAY, 0);
        expect_out("rst_snoopState", S_SSTATE, 0);
        expect_out("rst_snoopData", S_SDATA, 0);
        expect_out("rst_fillBusy", S_BUSY, 0);
        expect_out("rst_victimTag", S_VTAG, 0);
        expect_out("rst_victimState", S_VSTATE, 0);
        tick();

        // Gapped fill of idx 3 tag 0x2A, data 0x100+k
        fill_line(4'd3, 6'h2A, 2'd1, 16'h0100, 1'b1);
        expect_out("fill1_busy_done", S_BUSY, 0);
        cpu_look(4'd3, 6'h2A, 4'd5);
        snoop_look(4'd3, 6'h2A, 4'd9);
        expect_out("fill1_cpuHit", S_CHIT, 1);
        expect_out("fill1_cpuData", S_CDATA, 16'h0105);
        expect_out("fill1_cpuState", S_CSTATE, 1);
        expect_out("fill1_cpuWay", S_CWAY, 0);
        expect_out("fill1_cpuTag", S_CTAG, 6'h2A);
        expect_out("fill1_snoopHit", S_SHIT, 1);
        expect_out("fill1_snoopData", S_SDATA, 16'h0109);
        expect_out("fill1_snoopState", S_SSTATE, 1);
        tick();

        // CPU word write
        bus.cpuWriteData = 1'b1; bus.cpuDataIn = 16'hBEEF;
        tick();
        bus.cpuWriteData = 1'b0;
        expect_out("cpu_write_data", S_CDATA, 16'hBEEF);
        tick();

        // Fill every way of idx 3 with tags 1..4
        do_reset();
        for (int t = 1; t <= 4; t++) fill_line(4'd3, 6'(t), 2'd1, 16'(t * 16), 1'b0);
        for (int t = 1; t <= 4; t++) begin
            cpu_look(4'd3, 6'(t), 4'd0);
            expect_out("four_way_hit", S_CHIT, 1);
            expect_out("four_way_way", S_CWAY, 32'(t - 1));
            expect_out("four_way_data", S_CDATA, 32'(t * 16));
            tick();
        end

        // Touch tag 1 -> tag 2 (way 1) becomes LRU
        cpu_look(4'd3, 6'd1, 4'd0);
        bus.accessEnable = 1'b1;
        tick();
        bus.accessEnable = 1'b0;
        cpu_look(4'd3, 6'd9, 4'd0);
        expect_out("lru_miss_hit", S_CHIT, 0);
        expect_out("lru_victim_way", S_CWAY, 1);
        tick();

        done_q.push_back(1);
        fill_start(4'd3, 6'd5, 2'd1);
        expect_out("victim_tag", S_VTAG, 2);
        expect_out("victim_state", S_VSTATE, 1);
        cpu_look(4'd3, 6'd2, 4'd0);
        expect_out("victim_visible_hit", S_CHIT, 1);
        expect_out("victim_visible_way", S_CWAY, 1);
        // A second fillStart while busy must be ignored
        bus.fillStart = 1'b1; bus.fillIndex = 4'd7; bus.fillTag = 6'd9;
        fill_beats(16'h0500, 1, 1'b0);
        bus.fillStart = 1'b0;
        fill_beats(16'h0501, 15, 1'b0);
        tick();
        cpu_look(4'd3, 6'd5, 4'd3);
        expect_out("refill_hit", S_CHIT, 1);
        expect_out("refill_way", S_CWAY, 1);
        expect_out("refill_data", S_CDATA, 16'h0503);
        tick();
        cpu_look(4'd3, 6'd2, 4'd0);
        expect_out("evicted_miss", S_CHIT, 0);
        tick();
        cpu_look(4'd7, 6'd9, 4'd0);
        expect_out("ignored_start_miss", S_CHIT, 0);
        expect_out("ignored_start_idle", S_BUSY, 0);
        tick();

        // Snoop invalidate of tag 3 (way 2)
        snoop_look(4'd3, 6'd3, 4'd0);
        bus.snoopWriteState = 1'b1; bus.snoopStateIn = 2'd0;
        expect_out("snoop_inv_hit", S_SHIT, 1);
        expect_out("snoop_inv_way", S_SWAY, 2);
        expect_out("snoop_inv_state", S_SSTATE, 1);
        tick();
        bus.snoopWriteState = 1'b0;
        cpu_look(4'd3, 6'd3, 4'd0);
        expect_out("after_inv_miss", S_CHIT, 0);
        expect_out("after_inv_victim", S_CWAY, 2);
        tick();

        // Same-cycle CPU state 2 and snoop state 0 on tag 4 (way 3): snoop wins
        cpu_look(4'd3, 6'd4, 4'd0);
        bus.cpuWriteState = 1'b1; bus.cpuStateIn = 2'd2;
        snoop_look(4'd3, 6'd4, 4'd0);
        bus.snoopWriteState = 1'b1; bus.snoopStateIn = 2'd0;
        tick();
        bus.cpuWriteState = 1'b0; bus.snoopWriteState = 1'b0;
        expect_out("collide_cpu_miss", S_CHIT, 0);
        expect_out("collide_snoop_miss", S_SHIT, 0);
        tick();

        // CPU-only state write
        cpu_look(4'd3, 6'd5, 4'd0);
        bus.cpuWriteState = 1'b1; bus.cpuStateIn = 2'd3;
        tick();
        bus.cpuWriteState = 1'b0;
        expect_out("cpu_state_hit", S_CHIT, 1);
        expect_out("cpu_state_val", S_CSTATE, 3);
        tick();

        // Reset at beat 8 of a fill
        fill_start(4'd5, 6'd7, 2'd1);
        fill_beats(16'h0700, 8, 1'b0);
        reset = 1'b0;
        cpu_look(4'd5, 6'd7, 4'd0);
        expect_out("midfill_rst_busy", S_BUSY, 0);
        expect_out("midfill_rst_miss", S_CHIT, 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        expect_out("midfill_after_miss", S_CHIT, 0);
        expect_out("midfill_after_state", S_CSTATE, 0);
        expect_out("midfill_after_busy", S_BUSY, 0);
        tick();
        tick();

        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL fillDone_missing: got %0d fewer pulses, expected 0", done_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
